// File: rtl/ipg_tx.sv
// Transmit-side IPG inserter: queues side-channel bytes and writes them into the idle lanes of 64b/66b control blocks.
// Optional macro IPG_TX_IDLE_CHECK_EN: insert only into regions that are pure /I/ idle (all 0x00).
module ipg_tx #(
  parameter int BUF_BYTES = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [63:0]                  ipg_in_data,
  input  logic                         ipg_in_valid,
  output logic                         ipg_in_ready,
  input  logic [1:0]                   encoded_tx_hdr,
  input  logic [63:0]                  encoded_tx_data,
  output logic [1:0]                   ipg_encoded_tx_hdr,
  output logic [63:0]                  ipg_encoded_tx_data,
  output logic [5:0]                   tx_len,
  output logic [$clog2(BUF_BYTES):0]   buf_level
);

  localparam int PTR_W = $clog2(BUF_BYTES);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(BUF_BYTES - 8);

  logic [7:0]       r_buf [BUF_BYTES];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic [1:0]       r_hdr;
  logic [63:0]      r_data;
  logic [5:0]       r_len;

  logic             w_push;
  logic [2:0]       w_lo;
  logic [2:0]       w_cap;
  logic [7:0]       w_in_region;
  logic             w_ins_en;
  logic [2:0]       w_n;
  logic [PTR_W-1:0] w_rd_idx [8];
  logic [63:0]      w_out_data;

  assign ipg_in_ready        = (r_count <= READY_MAX);
  assign buf_level           = r_count;
  assign w_push              = ipg_in_valid && ipg_in_ready;
  assign ipg_encoded_tx_hdr  = r_hdr;
  assign ipg_encoded_tx_data = r_data;
  assign tx_len              = r_len;

  // Idle-lane region per block type: lowest lane index and lane count.
  always_comb begin
    w_lo  = 3'd0;
    w_cap = 3'd0;
    if (encoded_tx_hdr == 2'b01) begin
      case (encoded_tx_data[7:0])
        8'h1e:   begin w_lo = 3'd1; w_cap = 3'd7; end
        8'h2d:   begin w_lo = 3'd1; w_cap = 3'd3; end
        8'h33:   begin w_lo = 3'd1; w_cap = 3'd3; end
        8'h4b:   begin w_lo = 3'd5; w_cap = 3'd3; end
        8'h87:   begin w_lo = 3'd2; w_cap = 3'd6; end
        8'h99:   begin w_lo = 3'd3; w_cap = 3'd5; end
        8'haa:   begin w_lo = 3'd4; w_cap = 3'd4; end
        8'hb4:   begin w_lo = 3'd5; w_cap = 3'd3; end
        8'hcc:   begin w_lo = 3'd6; w_cap = 3'd2; end
        8'hd2:   begin w_lo = 3'd7; w_cap = 3'd1; end
        default: begin w_lo = 3'd0; w_cap = 3'd0; end
      endcase
    end
  end

  always_comb begin
    for (int l = 0; l < 8; l++) begin
      w_in_region[l] = (l >= int'(w_lo)) && (l < int'(w_lo) + int'(w_cap));
    end
  end

`ifdef IPG_TX_IDLE_CHECK_EN
  // Non-idle codes such as /E/ must survive untouched.
  logic [63:0] w_region_mask;
  always_comb begin
    for (int l = 0; l < 8; l++) begin
      w_region_mask[8*l +: 8] = {8{w_in_region[l]}};
    end
  end
  assign w_ins_en = ((encoded_tx_data & w_region_mask) == 64'd0);
`else
  assign w_ins_en = 1'b1;
`endif

  always_comb begin
    w_n = 3'd0;
    if (w_ins_en) begin
      w_n = (r_count < CNT_W'(w_cap)) ? r_count[2:0] : w_cap;
    end
  end

  always_comb begin
    for (int l = 0; l < 8; l++) begin
      w_rd_idx[l] = r_rd_ptr + PTR_W'(l) - PTR_W'(w_lo);
    end
  end

  // Fill region lanes in ascending order from the buffer head, zero the remainder.
  always_comb begin
    w_out_data = encoded_tx_data;
    for (int l = 0; l < 8; l++) begin
      if (w_ins_en && w_in_region[l]) begin
        if ((l - int'(w_lo)) < int'(w_n)) begin
          w_out_data[8*l +: 8] = r_buf[w_rd_idx[l]];
        end else begin
          w_out_data[8*l +: 8] = 8'h00;
        end
      end
    end
  end

  // Byte storage: holds no control state, so it is not reset.
  always_ff @(posedge clk) begin
    if (rst_n && w_push) begin
      for (int b = 0; b < 8; b++) begin
        r_buf[r_wr_ptr + PTR_W'(b)] <= ipg_in_data[8*b +: 8];
      end
    end
  end

  // Output register stage and buffer bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_hdr    <= 2'b00;
      r_data   <= 64'd0;
      r_len    <= 6'd0;
    end else begin
      r_hdr    <= encoded_tx_hdr;
      r_data   <= w_out_data;
      r_len    <= {w_n, 3'b000};
      r_rd_ptr <= r_rd_ptr + PTR_W'(w_n);
      r_wr_ptr <= r_wr_ptr + (w_push ? PTR_W'(8) : PTR_W'(0));
      r_count  <= r_count + (w_push ? CNT_W'(8) : CNT_W'(0)) - CNT_W'(w_n);
    end
  end

endmodule

// File: tb/tb_ipg_tx.sv
// Directed bench for ipg_tx with hand-computed expectations; honours IPG_TX_IDLE_CHECK_EN.
module tb_ipg_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] ipg_in_data;
  logic        ipg_in_valid;
  logic        ipg_in_ready;
  logic [1:0]  encoded_tx_hdr;
  logic [63:0] encoded_tx_data;
  logic [1:0]  ipg_encoded_tx_hdr;
  logic [63:0] ipg_encoded_tx_data;
  logic [5:0]  tx_len;
  logic [5:0]  buf_level;

  int n_cmp  = 0;
  int n_fail = 0;

  ipg_tx #(.BUF_BYTES(32)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .ipg_in_data         (ipg_in_data),
    .ipg_in_valid        (ipg_in_valid),
    .ipg_in_ready        (ipg_in_ready),
    .encoded_tx_hdr      (encoded_tx_hdr),
    .encoded_tx_data     (encoded_tx_data),
    .ipg_encoded_tx_hdr  (ipg_encoded_tx_hdr),
    .ipg_encoded_tx_data (ipg_encoded_tx_data),
    .tx_len              (tx_len),
    .buf_level           (buf_level)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic blk(input logic [1:0] hdr, input logic [63:0] data);
    encoded_tx_hdr  = hdr;
    encoded_tx_data = data;
    tick();
  endtask

  task automatic chk_out(input string tag, input logic [63:0] data, input int len, input int lvl);
    check({tag, ".data"}, ipg_encoded_tx_data, data);
    check({tag, ".len"},  64'(tx_len), 64'(len));
    check({tag, ".lvl"},  64'(buf_level), 64'(lvl));
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    ipg_in_valid = 1'b0;
    encoded_tx_hdr  = 2'b10;
    encoded_tx_data = 64'd0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n           = 1'b0;
    ipg_in_data     = 64'd0;
    ipg_in_valid    = 1'b0;
    encoded_tx_hdr  = 2'b00;
    encoded_tx_data = 64'd0;
    tick();
    tick();
    check("rst.hdr",   64'(ipg_encoded_tx_hdr), 64'd0);
    check("rst.data",  ipg_encoded_tx_data, 64'd0);
    check("rst.len",   64'(tx_len), 64'd0);
    check("rst.lvl",   64'(buf_level), 64'd0);
    check("rst.ready", 64'(ipg_in_ready), 64'd1);

    // Single word push, then a full 0x1e drain and a partial 0xaa.
    rst_n        = 1'b1;
    ipg_in_valid = 1'b1;
    ipg_in_data  = 64'h08070605_04030201;
    blk(2'b10, 64'd0);
    check("push1.lvl", 64'(buf_level), 64'd8);
    ipg_in_valid = 1'b0;
    blk(2'b01, 64'h1e);
    chk_out("t1e", 64'h07060504_0302011e, 56, 1);
    blk(2'b01, 64'hFFFFFFFF_00BBAAaa);
`ifdef IPG_TX_IDLE_CHECK_EN
    chk_out("taa", 64'hFFFFFFFF_00BBAAaa, 0, 1);
`else
    chk_out("taa", 64'h00000008_00BBAAaa, 8, 0);
`endif
    blk(2'b10, 64'hDEADBEEF_CAFEF00D);
    check("dblk.hdr", 64'(ipg_encoded_tx_hdr), 64'd2);
    check("dblk.data", ipg_encoded_tx_data, 64'hDEADBEEF_CAFEF00D);
    check("dblk.len", 64'(tx_len), 64'd0);

    // Empty buffer: region zeroed (or passed through when idle check rejects it).
    do_reset();
    blk(2'b01, 64'hAABBCCDD_EEFF111e);
`ifdef IPG_TX_IDLE_CHECK_EN
    chk_out("empty1e", 64'hAABBCCDD_EEFF111e, 0, 0);
`else
    chk_out("empty1e", 64'h00000000_0000001e, 0, 0);
`endif

    // Fill to capacity, drain around the ready threshold, push and pop together.
    do_reset();
    ipg_in_valid = 1'b1;
    ipg_in_data  = 64'h17161514_13121110;
    blk(2'b10, 64'd0);
    check("fill.lvl8", 64'(buf_level), 64'd8);
    ipg_in_data = 64'h1F1E1D1C_1B1A1918;
    blk(2'b10, 64'd0);
    check("fill.lvl16", 64'(buf_level), 64'd16);
    ipg_in_data = 64'h27262524_23222120;
    blk(2'b10, 64'd0);
    check("fill.lvl24", 64'(buf_level), 64'd24);
    ipg_in_data = 64'h2F2E2D2C_2B2A2928;
    blk(2'b10, 64'd0);
    check("fill.lvl32", 64'(buf_level), 64'd32);
    check("fill.ready0", 64'(ipg_in_ready), 64'd0);
    ipg_in_data = 64'h37363534_33323130;
    blk(2'b10, 64'd0);
    check("full.hold", 64'(buf_level), 64'd32);
    blk(2'b01, 64'h1e);
    chk_out("pop1", 64'h16151413_1211101e, 56, 25);
    check("pop1.ready", 64'(ipg_in_ready), 64'd0);
    blk(2'b01, 64'h1e);
    chk_out("pop2", 64'h1D1C1B1A_1918171e, 56, 18);
    check("pop2.ready", 64'(ipg_in_ready), 64'd1);
    blk(2'b01, 64'h1e);
    chk_out("pushpop", 64'h24232221_201F1E1e, 56, 19);
    ipg_in_valid = 1'b0;

    // Mixed block types across the 32-byte wrap.
    blk(2'b01, 64'hd2);
    chk_out("td2", 64'h25000000_000000d2, 8, 18);
    blk(2'b01, 64'h87);
    chk_out("t87", 64'h2B2A2928_27260087, 48, 12);
    blk(2'b01, 64'h00001122_334455cc);
    chk_out("tcc", 64'h2D2C1122_334455cc, 16, 10);
    blk(2'b01, 64'hFFEEDDCC_BBAA99ff);
    chk_out("tff", 64'hFFEEDDCC_BBAA99ff, 0, 10);
    blk(2'b01, 64'h4b);
    chk_out("t4b", 64'h302F2E00_0000004b, 24, 7);
    blk(2'b01, 64'h2d);
    chk_out("t2d", 64'h00000000_3332312d, 24, 4);
    blk(2'b01, 64'h1e);
    chk_out("tpart", 64'h00000037_3635341e, 32, 0);

    // /E/ code in the region, then reset mid-fill.
    do_reset();
    ipg_in_valid = 1'b1;
    ipg_in_data  = 64'h47464544_43424140;
    blk(2'b10, 64'd0);
    ipg_in_valid = 1'b0;
    blk(2'b01, 64'h00000000_00001e1e);
`ifdef IPG_TX_IDLE_CHECK_EN
    chk_out("err1e", 64'h00000000_00001e1e, 0, 8);
`else
    chk_out("err1e", 64'h46454443_4241401e, 56, 1);
`endif
    ipg_in_valid = 1'b1;
    ipg_in_data  = 64'h5F5E5D5C_5B5A5958;
    blk(2'b10, 64'h1234);
    rst_n = 1'b0;
    blk(2'b01, 64'h1e);
    check("mrst.hdr",   64'(ipg_encoded_tx_hdr), 64'd0);
    check("mrst.data",  ipg_encoded_tx_data, 64'd0);
    check("mrst.len",   64'(tx_len), 64'd0);
    check("mrst.lvl",   64'(buf_level), 64'd0);
    check("mrst.ready", 64'(ipg_in_ready), 64'd1);
    rst_n        = 1'b1;
    ipg_in_valid = 1'b0;
    blk(2'b01, 64'h1e);
    chk_out("post", 64'h00000000_0000001e, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
